// File: rtl/ram_rmw_sequencer_if.sv
// RAM-side bus of the pushbutton read-modify-write sequencer.
// The sequencer drives address/data/write-enable; the RAM returns registered read data.
interface ram_rmw_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] din;
  logic              we;
  logic [DATA_W-1:0] dout;

  modport master (
    output a,
    output din,
    output we,
    input  dout
  );

  modport slave (
    input  a,
    input  din,
    input  we,
    output dout
  );
endinterface

// File: rtl/ram_rmw_sequencer.sv
// Debounces four pushbuttons and turns each press into a RAM address step or a
// read-modify-write (+1/-1) on the addressed word of a registered-read RAM.
module ram_rmw_sequencer #(
  parameter int ADDR_W          = 4,
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           KEY,
  output logic                 busy,
  ram_rmw_sequencer_if.master  ram
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MOD,
    S_WR,
    S_SETTLE
  } state_e;

  logic [3:0]        key_meta_q, key_sync_q;
  logic [3:0]        key_acc_q, key_acc_d;
  logic [3:0]        evt_q, evt_d;
  logic [CNT_W-1:0]  cnt_q [4];
  logic [CNT_W-1:0]  cnt_d [4];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              dec_q, dec_d;

  // ---------------------------------------------------------------------------
  // Key path: 2-flop synchroniser, per-key debounce counter, press detection.
  // ---------------------------------------------------------------------------
  // NOTE: registers are written with non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 4'hF;
      key_sync_q <= 4'hF;
      key_acc_q  <= 4'hF;
      evt_q      <= 4'h0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      key_meta_q <= KEY;
      key_sync_q <= key_meta_q;
      key_acc_q  <= key_acc_d;
      evt_q      <= evt_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // The accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; a 1->0 flip is a press and yields a single-cycle event.
  always_comb begin
    key_acc_d = key_acc_q;
    evt_d     = 4'h0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (key_sync_q[i] != key_acc_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          key_acc_d[i] = key_sync_q[i];
          evt_d[i]     = key_acc_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM: address steps in IDLE, data commands as RD/MOD/WR/SETTLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      din_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      din_q   <= din_d;
      dec_q   <= dec_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    din_d   = din_q;
    dec_d   = dec_q;
    unique case (state_q)
      S_IDLE: begin
        // Fixed priority KEY3 > KEY2 > KEY1 > KEY0; losing events are dropped.
        if (evt_q[3]) begin
          a_d = a_q + ADDR_ONE;
        end else if (evt_q[2]) begin
          a_d = a_q - ADDR_ONE;
        end else if (evt_q[1]) begin
          state_d = S_RD;
          dec_d   = 1'b0;
        end else if (evt_q[0]) begin
          state_d = S_RD;
          dec_d   = 1'b1;
        end
      end
      S_RD:  state_d = S_MOD;
      S_MOD: begin
        din_d   = dec_q ? (ram.dout - DATA_ONE) : (ram.dout + DATA_ONE);
        state_d = S_WR;
      end
      S_WR:     state_d = S_SETTLE;
      // The RAM returns old data on the write edge; one extra cycle lets
      // dout show the written value by the time the FSM is back in IDLE.
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign ram.a   = a_q;
  assign ram.din = din_q;
  assign ram.we  = (state_q == S_WR);
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_rmw_sequencer.sv
// Directed bench for ram_rmw_sequencer: behavioural 16x8 registered-read RAM,
// table-driven address steps and hand-written read-modify-write corner cases.
module tb_ram_rmw_sequencer;

  localparam int D    = 4;
  localparam int HOLD = 3 * D;
  localparam int GAP  = 3 * D + 10;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic       busy;

  ram_rmw_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_rmw_sequencer #(
    .ADDR_W(4),
    .DATA_W(8),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .KEY   (key),
    .busy  (busy),
    .ram   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, old data on read-during-write, plus a
  // bench-only preload port.
  logic [7:0] mem [16];
  logic       pre_we;
  logic [3:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.we) mem[bus.a] <= bus.din;
    bus.dout <= mem[bus.a];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation of write pulses and busy windows, sampled at negedge.
  int         we_cnt = 0, we_cyc = 0, rise_cyc = 0, fall_cyc = 0, a_viol = 0;
  logic [3:0] we_a;
  logic [7:0] we_din, fall_dout;
  logic       busy_prev = 1'b0;
  logic [3:0] a_prev = 4'h0;

  always @(negedge clk) begin
    if (bus.we) begin
      we_cnt++;
      we_cyc = cyc;
      we_a   = bus.a;
      we_din = bus.din;
    end
    if (busy && !busy_prev) rise_cyc = cyc;
    if (!busy && busy_prev) begin
      fall_cyc  = cyc;
      fall_dout = bus.dout;
    end
    if (busy && busy_prev && (bus.a != a_prev)) a_viol++;
    busy_prev = busy;
    a_prev    = bus.a;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic preload(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic press(input logic [3:0] keys_n, input int hold);
    @(negedge clk);
    key = keys_n;
    repeat (hold) @(negedge clk);
    key = 4'hF;
    repeat (GAP) @(negedge clk);
  endtask

  typedef struct {
    logic       do_reset;
    logic [3:0] keys_n;
    logic [3:0] exp_a;
  } addr_vec_t;

  addr_vec_t vecs [19];

  initial begin
    int w0;
    logic seen;

    key    = 4'hF;
    rst_n  = 1'b0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;

    // Address steps: 17 KEY3 presses from reset, then reset and two KEY2 presses.
    for (int i = 0; i < 17; i++) begin
      vecs[i].do_reset = (i == 0);
      vecs[i].keys_n   = 4'b0111;
      vecs[i].exp_a    = 4'((i + 1) % 16);
    end
    vecs[17] = '{do_reset: 1'b1, keys_n: 4'b1011, exp_a: 4'd15};
    vecs[18] = '{do_reset: 1'b0, keys_n: 4'b1011, exp_a: 4'd14};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_reset();
    check("reset_a",    32'(bus.a),   32'h0);
    check("reset_din",  32'(bus.din), 32'h0);
    check("reset_we",   32'(bus.we),  32'h0);
    check("reset_busy", 32'(busy),    32'h0);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].do_reset) do_reset();
      w0 = we_cnt;
      press(vecs[i].keys_n, HOLD);
      check($sformatf("addr_step%0d_a", i), 32'(bus.a), 32'(vecs[i].exp_a));
      check($sformatf("addr_step%0d_we", i), 32'(we_cnt - w0), 32'h0);
    end

    // mem[0]=0xFF, KEY1: single write of 0x00 two cycles after busy rises.
    do_reset();
    preload(4'd0, 8'hFF);
    w0 = we_cnt;
    press(4'b1101, HOLD);
    check("inc_we_count",   32'(we_cnt - w0),         32'd1);
    check("inc_we_timing",  32'(we_cyc - rise_cyc),   32'd2);
    check("inc_busy_len",   32'(fall_cyc - rise_cyc), 32'd4);
    check("inc_we_a",       32'(we_a),                32'h0);
    check("inc_we_din",     32'(we_din),              32'h00);
    check("inc_dout_idle",  32'(fall_dout),           32'h00);
    check("inc_mem0",       32'(mem[0]),              32'h00);
    check("inc_busy_after", 32'(busy),                32'h0);

    // mem[3]=0x00 at a=3, KEY0 wraps to 0xFF; a 100-cycle hold writes once.
    do_reset();
    preload(4'd3, 8'h00);
    repeat (3) press(4'b0111, HOLD);
    check("dec_a3", 32'(bus.a), 32'd3);
    w0 = we_cnt;
    press(4'b1110, HOLD);
    check("dec_we_count", 32'(we_cnt - w0), 32'd1);
    check("dec_we_din",   32'(we_din),      32'hFF);
    check("dec_mem3",     32'(mem[3]),      32'hFF);
    w0 = we_cnt;
    press(4'b1110, 100);
    check("held_we_count", 32'(we_cnt - w0), 32'd1);
    check("held_mem3",     32'(mem[3]),      32'hFE);

    // Bounce shorter than the debounce window produces nothing.
    w0 = we_cnt;
    @(negedge clk);
    key = 4'b1101;
    repeat (D - 1) @(negedge clk);
    key = 4'hF;
    repeat (GAP) @(negedge clk);
    check("bounce_we", 32'(we_cnt - w0), 32'd0);
    check("bounce_a",  32'(bus.a),       32'd3);
    check("bounce_mem3", 32'(mem[3]),    32'hFE);

    // KEY3 and KEY1 together: address step wins, data command dropped.
    w0 = we_cnt;
    press(4'b0101, HOLD);
    check("simul_a",  32'(bus.a),       32'd4);
    check("simul_we", 32'(we_cnt - w0), 32'd0);

    // KEY2 event arriving two cycles into a KEY1 transaction is dropped.
    preload(4'd4, 8'h10);
    w0 = we_cnt;
    @(negedge clk);
    key = 4'b1101;
    repeat (2) @(negedge clk);
    key = 4'b1001;
    repeat (HOLD) @(negedge clk);
    key = 4'hF;
    repeat (GAP) @(negedge clk);
    check("busy_drop_a",    32'(bus.a),       32'd4);
    check("busy_drop_we",   32'(we_cnt - w0), 32'd1);
    check("busy_drop_mem4", 32'(mem[4]),      32'h11);
    check("busy_drop_dout", 32'(fall_dout),   32'h11);

    // Reset asserted while in MOD: no write, outputs back to reset values.
    do_reset();
    preload(4'd0, 8'h5A);
    w0   = we_cnt;
    seen = 1'b0;
    key  = 4'b1101;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("rstmid_busy_seen", 32'(seen), 32'h1);
    key = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_we",   32'(bus.we),  32'h0);
    check("rstmid_busy", 32'(busy),    32'h0);
    check("rstmid_a",    32'(bus.a),   32'h0);
    check("rstmid_din",  32'(bus.din), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (GAP) @(negedge clk);
    check("rstmid_no_write", 32'(we_cnt - w0), 32'd0);
    check("rstmid_mem0",     32'(mem[0]),      32'h5A);
    check("rstmid_idle",     32'(busy),        32'h0);

    check("a_stable_while_busy", 32'(a_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
